// File: rtl/cpu_mon_pkg.sv
// Shared state encoding, halt-instruction default and saturating increment
// used by the CPU run monitor.
package cpu_mon_pkg;

   typedef enum logic [1:0] {
      MON_RUN     = 2'd0,
      MON_HALTED  = 2'd1,
      MON_TIMEOUT = 2'd2
   } mon_state_e;

   localparam logic [31:0] CPU_MON_HALT_INSN_DEFAULT = 32'h0000_006F;

   // Operates on a 64-bit carrier so any counter width up to 64 can share it.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input logic [63:0] max_value);
      return (value >= max_value) ? max_value : value + 64'd1;
   endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Observation bundle of the core's fetch and write strobes; the core side
// drives it (master), the run monitor watches it (slave).
interface cpu_run_monitor_if #(
   parameter int unsigned XLEN = 32
);
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_pc;
   logic [31:0]     fetch_insn;
   logic            reg_write;
   logic            mem_write;

   modport master (
      output fetch_valid, fetch_pc, fetch_insn, reg_write, mem_write
   );

   modport slave (
      input fetch_valid, fetch_pc, fetch_insn, reg_write, mem_write
   );
endinterface

// File: rtl/cpu_mon_hist_buf.sv
// Circular buffer of the most recently fetched PCs; index 0 reads the newest
// entry and indices at or beyond the fill level read as zero.
module cpu_mon_hist_buf #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [XLEN-1:0]          wr_pc,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [XLEN-1:0]          rd_pc,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic [XLEN-1:0] ent [DEPTH];
   logic [AW-1:0]   rd_addr;

   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [XLEN-1:0] ent_q, ent_d;

      always_comb begin
         ent_d = ent_q;
         if (clear) begin
            ent_d = '0;
         end else if (wr_en && (wr_ptr_q == AW'(gi))) begin
            ent_d = wr_pc;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ent_q <= '0;
         end else begin
            ent_q <= ent_d;
         end
      end

      assign ent[gi] = ent_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         level_d  = '0;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (level_q != LEVEL_FULL) begin
            level_d = level_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   // The newest entry sits just behind the write pointer; wrap is modulo DEPTH.
   assign rd_addr = wr_ptr_q - AW'(1) - rd_idx;
   assign rd_pc   = ({1'b0, rd_idx} < level_q) ? ent[rd_addr] : '0;
   assign level   = level_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the multicycle RV32 core: statistics counters, halt
// detection and a cycle watchdog. PC history is built only with CPU_MON_HIST_EN.
module cpu_run_monitor
   import cpu_mon_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 1000,
   parameter logic [31:0] HALT_INSN  = CPU_MON_HALT_INSN_DEFAULT,
   parameter int unsigned HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   cpu_run_monitor_if.slave              mon,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
   output logic [XLEN-1:0]               hist_rd_pc,
   output logic [$clog2(HIST_DEPTH):0]   hist_level,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [CNT_W-1:0]              insn_count,
   output logic [CNT_W-1:0]              regwr_count,
   output logic [CNT_W-1:0]              memwr_count,
   output logic                          halted,
   output logic                          timeout,
   output logic                          done
);
   localparam logic [63:0]      CNT_MAX = {64{1'b1}} >> (64 - CNT_W);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

   mon_state_e       state_q, state_d;
   logic             counting;
   logic             halt_fetch;
   logic [3:0]       strobe;
   logic [CNT_W-1:0] cnt_cur [4];
   logic [CNT_W-1:0] cnt_nxt [4];

   // A clear in the same cycle wins over every event, so nothing is counted.
   assign counting   = (state_q == MON_RUN) && !clear;
   assign halt_fetch = mon.fetch_valid && (mon.fetch_insn == HALT_INSN);
   assign strobe     = {mon.mem_write, mon.reg_write, mon.fetch_valid, 1'b1};

   // Slot 0 counts cycles, then fetches, register writes and memory writes.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [63:0]      cnt_inc;

      always_comb begin
         cnt_inc = sat_inc(64'(cnt_q), CNT_MAX);
         cnt_d   = cnt_q;
         if (clear) begin
            cnt_d = '0;
         end else if (counting && strobe[gi]) begin
            cnt_d = cnt_inc[CNT_W-1:0];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_cur[gi] = cnt_q;
      assign cnt_nxt[gi] = cnt_d;
   end

   assign cycle_count = cnt_cur[0];
   assign insn_count  = cnt_cur[1];
   assign regwr_count = cnt_cur[2];
   assign memwr_count = cnt_cur[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MON_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Halt is tested first so it wins over a watchdog expiring in the same cycle.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = MON_RUN;
      end else if (state_q == MON_RUN) begin
         if (halt_fetch) begin
            state_d = MON_HALTED;
         end else if (cnt_nxt[0] == MAX_C) begin
            state_d = MON_TIMEOUT;
         end
      end
   end

   always_comb begin
      halted  = 1'b0;
      timeout = 1'b0;
      case (state_q)
         MON_HALTED:  halted  = 1'b1;
         MON_TIMEOUT: timeout = 1'b1;
         default:     ;
      endcase
      done = halted | timeout;
   end

`ifdef CPU_MON_HIST_EN
   cpu_mon_hist_buf #(
      .XLEN  (XLEN),
      .DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .wr_en  (counting && mon.fetch_valid),
      .wr_pc  (mon.fetch_pc),
      .rd_idx (hist_rd_idx),
      .rd_pc  (hist_rd_pc),
      .level  (hist_level)
   );
`else
   logic unused_hist;
   assign unused_hist = ^{hist_rd_idx, mon.fetch_pc};
   assign hist_rd_pc  = '0;
   assign hist_level  = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor against a queue-based run model;
// history expectations follow CPU_MON_HIST_EN.
`timescale 1ns/1ps
module tb_cpu_run_monitor;
   localparam int          HD   = 8;
   localparam int          MAXC = 50;
   localparam logic [31:0] HALT = 32'h0000_006F;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [2:0]  hist_rd_idx;
   logic [31:0] hist_rd_pc;
   logic [3:0]  hist_level;
   logic [31:0] cycle_count, insn_count, regwr_count, memwr_count;
   logic        halted, timeout, done;

   cpu_run_monitor_if #(.XLEN(32)) mon_if ();

   cpu_run_monitor #(
      .XLEN       (32),
      .CNT_W      (32),
      .MAX_CYCLES (MAXC),
      .HALT_INSN  (HALT),
      .HIST_DEPTH (HD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .mon         (mon_if.slave),
      .hist_rd_idx (hist_rd_idx),
      .hist_rd_pc  (hist_rd_pc),
      .hist_level  (hist_level),
      .cycle_count (cycle_count),
      .insn_count  (insn_count),
      .regwr_count (regwr_count),
      .memwr_count (memwr_count),
      .halted      (halted),
      .timeout     (timeout),
      .done        (done)
   );

   always #10 clk = ~clk;

   // Reference model: plain counts, two flags and newest-first PC queue.
   int unsigned m_cyc, m_insn, m_rw, m_mw;
   bit          m_halt, m_to;
   logic [31:0] m_hist [$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_level();
`ifdef CPU_MON_HIST_EN
      return 64'(m_hist.size());
`else
      return 64'd0;
`endif
   endfunction

   function automatic logic [63:0] exp_pc(input int idx);
`ifdef CPU_MON_HIST_EN
      return (idx < m_hist.size()) ? 64'(m_hist[idx]) : 64'd0;
`else
      return 64'd0;
`endif
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_insn = 0; m_rw = 0; m_mw = 0;
      m_halt = 1'b0; m_to = 1'b0;
      m_hist.delete();
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "_cyc"},   64'(cycle_count), 64'(m_cyc));
      check_val({tag, "_insn"},  64'(insn_count),  64'(m_insn));
      check_val({tag, "_rw"},    64'(regwr_count), 64'(m_rw));
      check_val({tag, "_mw"},    64'(memwr_count), 64'(m_mw));
      check_val({tag, "_halt"},  64'(halted),      64'(m_halt));
      check_val({tag, "_to"},    64'(timeout),     64'(m_to));
      check_val({tag, "_done"},  64'(done),        64'(m_halt | m_to));
      check_val({tag, "_level"}, 64'(hist_level),  exp_level());
      check_val({tag, "_hpc"},   64'(hist_rd_pc),  exp_pc(int'(hist_rd_idx)));
   endtask

   task automatic check_hist_all(input string tag);
      for (int i = 0; i < HD; i++) begin
         hist_rd_idx = 3'(i);
         #1;
         check_val($sformatf("%s_idx%0d", tag, i), 64'(hist_rd_pc), exp_pc(i));
      end
   endtask

   // One clock of stimulus: drive at negedge, update model and check after posedge.
   task automatic step(input string tag, input bit fv, input logic [31:0] pc,
                       input logic [31:0] insn, input bit rw, input bit mw, input bit clr);
      @(negedge clk);
      mon_if.fetch_valid = fv;
      mon_if.fetch_pc    = pc;
      mon_if.fetch_insn  = insn;
      mon_if.reg_write   = rw;
      mon_if.mem_write   = mw;
      clear              = clr;
      hist_rd_idx        = 3'($urandom_range(0, HD - 1));
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else if (!(m_halt || m_to)) begin
         m_cyc++;
         if (fv) begin
            m_insn++;
            m_hist.push_front(pc);
            if (m_hist.size() > HD) m_hist = m_hist[0:HD-1];
         end
         if (rw) m_rw++;
         if (mw) m_mw++;
         if (fv && insn == HALT) m_halt = 1'b1;
         else if (m_cyc == MAXC) m_to = 1'b1;
      end
      #1;
      $display("[TB] %s fv=%0d pc=%08h insn=%08h rw=%0d mw=%0d clr=%0d -> cyc=%0d insn=%0d rw=%0d mw=%0d halted=%0d timeout=%0d lvl=%0d",
               tag, fv, pc, insn, rw, mw, clr, cycle_count, insn_count, regwr_count,
               memwr_count, halted, timeout, hist_level);
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      w = $urandom();
      if (w == HALT) w = w ^ 32'h1;
      return w;
   endfunction

   task automatic rand_step(input string tag, input bit allow_halt, input bit allow_clear);
      logic [31:0] insn;
      bit          fv;
      insn = rand_insn();
      fv   = ($urandom_range(0, 2) != 0);
      if (allow_halt && $urandom_range(0, 39) == 0) insn = HALT;
      step(tag, fv, {$urandom_range(0, 1023), 2'b00}, insn,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           allow_clear && ($urandom_range(0, 59) == 0));
   endtask

   initial begin
      reset = 1'b1;
      clear = 1'b0;
      hist_rd_idx = '0;
      mon_if.fetch_valid = 1'b0;
      mon_if.fetch_pc    = '0;
      mon_if.fetch_insn  = '0;
      mon_if.reg_write   = 1'b0;
      mon_if.mem_write   = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      check_all("reset");
      reset = 1'b0;

      // Five fetches with three register writes and one memory write, then halt.
      for (int i = 0; i < 5; i++) begin
         step("s1_fetch", 1'b1, 32'(4 * i), NOP, (i % 2) == 0, i == 1, 1'b0);
      end
      step("s1_halt", 1'b1, 32'h14, HALT, 1'b0, 1'b0, 1'b0);
      check_val("s1_halted", 64'(halted), 64'd1);
      check_val("s1_insn6",  64'(insn_count), 64'd6);
      check_val("s1_rw3",    64'(regwr_count), 64'd3);
      check_val("s1_mw1",    64'(memwr_count), 64'd1);
      for (int i = 0; i < 20; i++) rand_step("s1_frozen", 1'b1, 1'b0);
      check_val("s1_frozen_insn", 64'(insn_count), 64'd6);

      // Clear together with a fetch while halted: back to RUN, fetch discarded.
      step("s2_clear", 1'b1, 32'h100, NOP, 1'b1, 1'b1, 1'b1);
      check_val("s2_insn0", 64'(insn_count), 64'd0);
      check_val("s2_done0", 64'(done), 64'd0);

      // Watchdog with no halt fetch.
      for (int i = 0; i < 55; i++) rand_step("s3_run", 1'b0, 1'b0);
      check_val("s3_timeout", 64'(timeout), 64'd1);
      check_val("s3_cyc50",   64'(cycle_count), 64'(MAXC));
      check_val("s3_halt0",   64'(halted), 64'd0);

      // Halt fetch on the exact cycle the watchdog would fire.
      step("s4_clear", 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < MAXC - 1; i++) rand_step("s4_run", 1'b0, 1'b0);
      step("s4_halt", 1'b1, 32'h200, HALT, 1'b0, 1'b0, 1'b0);
      check_val("s4_halted", 64'(halted), 64'd1);
      check_val("s4_to0",    64'(timeout), 64'd0);

      // History wrap: ten fetches into eight entries, then a short fresh run.
      step("s5_clear", 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step("s5_fetch", 1'b1, 32'(4 * i), NOP, 1'b0, 1'b0, 1'b0);
      check_hist_all("s5_wrap");
      step("s5_clear2", 1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("s5_fresh", 1'b1, 32'(32'h40 + 4 * i), NOP, 1'b0, 1'b0, 1'b0);
      check_hist_all("s5_fresh");

      // Asynchronous reset in the middle of a run.
      for (int i = 0; i < 7; i++) rand_step("s6_run", 1'b0, 1'b0);
      #4;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("s6_async");
      mon_if.fetch_valid = 1'b0;
      mon_if.reg_write   = 1'b0;
      mon_if.mem_write   = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b0;

      // Long random mix with occasional halts and clears.
      for (int i = 0; i < 400; i++) begin
         rand_step("s7_rand", 1'b1, 1'b1);
         if (i % 50 == 49) check_hist_all("s7_hist");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run monitor for the multicycle RV32 core. It observes the core's fetch, register-write and memory-write strobes, and counts cycles, retired fetches and writes. It detects the end-of-program instruction (default JAL x0,0 = 0x0000006F) and enforces a cycle-limit watchdog. An optional circular history of the last fetched PCs is readable by index. It sits beside `cpu` and gives benches and FPGA debug a single done/halted/timeout indication plus statistics.

## Interface
- `XLEN`, 32, PC/address width
- `CNT_W`, 32, width of every counter
- `MAX_CYCLES`, 1000, watchdog limit in RUN cycles (must be ≥1 and < 2^CNT_W)
- `HALT_INSN`, 32'h0000006F, instruction word that ends the run
- `HIST_DEPTH`, 8, PC history entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous restart: same effect as reset
- `fetch_valid`  in  1  one-cycle pulse; `fetch_pc`/`fetch_insn` are valid this cycle
- `fetch_pc`  in  XLEN  address of fetched instruction
- `fetch_insn`  in  32  fetched instruction word
- `reg_write`  in  1  register-file write strobe
- `mem_write`  in  1  data-memory write strobe
- `hist_rd_idx`  in  $clog2(HIST_DEPTH)  0 = most recent fetch
- `hist_rd_pc`  out  XLEN  PC at `hist_rd_idx` (combinational read)
- `hist_level`  out  $clog2(HIST_DEPTH)+1  number of valid history entries
- `cycle_count`, `insn_count`, `regwr_count`, `memwr_count`  out  CNT_W  statistics
- `halted`  out  1  halt instruction seen
- `timeout`  out  1  watchdog expired
- `done`  out  1  `halted | timeout`

## Operation
- States: RUN, HALTED, TIMEOUT. Reset and `clear` enter RUN.
- RUN, each cycle:
  - `cycle_count` +1.
  - `insn_count` +1 on `fetch_valid`.
  - `regwr_count` +1 on `reg_write`.
  - `memwr_count` +1 on `mem_write`.
  - All counters saturate at all-ones.
- RUN → HALTED when `fetch_valid` is set and `fetch_insn == HALT_INSN`. The halt fetch is counted and recorded in the history.
- RUN → TIMEOUT when the cycle being counted brings `cycle_count` to `MAX_CYCLES`.
- Halt and timeout in the same cycle: HALTED wins and `timeout` stays 0.
- HALTED and TIMEOUT are terminal until reset or `clear`. All counters and the history freeze; strobes are ignored.
- `clear` takes priority over every event in the same cycle; that cycle's events are not counted.
- History:
  - Write pointer advances on every counted `fetch_valid` and wraps modulo HIST_DEPTH.
  - `hist_level` saturates at HIST_DEPTH.
  - Reading an index ≥ `hist_level` returns 0.
- Reset values: all counters 0, `hist_level` 0, `halted`/`timeout`/`done` 0, history contents 0, `hist_rd_pc` 0.

## Timing
- All outputs except `hist_rd_pc` are registered and update on the `clk` edge after the causing input.
- `hist_rd_pc` is combinational from `hist_rd_idx` and stored state.
- A `fetch_valid` at edge N is visible in `insn_count`, `halted` and history index 0 after edge N.
- `timeout` asserts after the edge on which `cycle_count` becomes `MAX_CYCLES`.
- Reset asserted mid-run clears everything immediately (asynchronous). The first counted cycle is the first edge after reset deasserts.

## Configuration
- `CPU_MON_HIST_EN` defined: PC history buffer, `hist_level` and `hist_rd_pc` are implemented as above.
- Not defined: no history storage is built. `hist_rd_pc` and `hist_level` are tied to 0. Counters and the FSM are unchanged.

## Structure
- Package `cpu_mon_pkg`:
  - state encoding (RUN/HALTED/TIMEOUT)
  - `CPU_MON_HALT_INSN_DEFAULT` = 32'h0000006F
  - saturating-increment helper function
- One sub-module, `cpu_mon_hist_buf`: circular PC buffer with write pointer, level and indexed read. It is instantiated only under `CPU_MON_HIST_EN`.

## Test plan
- Reset, then 5 fetches with 3 `reg_write` and 1 `mem_write`, then fetch 0x0000006F → `halted`=1, `done`=1, `insn_count`=6, `regwr_count`=3, `memwr_count`=1; counters stay frozen over 20 more cycles.
- `MAX_CYCLES`=50, no halt fetch → `timeout`=1 after edge 50, `cycle_count`=50, `halted`=0.
- Halt fetch on the exact cycle the watchdog would fire → `halted`=1, `timeout`=0.
- 10 fetches at PCs 0x00, 0x04, …, 0x24 with `HIST_DEPTH`=8 → `hist_level`=8, idx0=0x24, idx7=0x08; a fresh run of 3 fetches gives idx3 → 0.
- `clear` pulsed together with `fetch_valid` in HALTED → back to RUN with all counters 0; the fetch is not counted.
- Build without `CPU_MON_HIST_EN`, repeat scenario 1 → same counts; `hist_rd_pc`=0 and `hist_level`=0 throughout.
